sparse_mac_acc: RTL

Parametrised multiply-accumulate engine for the sparse datapath. It scans N operand slots and takes at most one valid (a, b) pair per cycle under round-robin arbitration, acknowledging each pair it takes. It multiplies the pair signed and accumulates the product into a wide accumulator over a 3-stage pipeline. On a flush command it drains the pipeline and presents the dot-product result with a one-cycle done pulse.

---
 rtl/sparse_mac_acc.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sparse_mac_acc.sv
// sparse_mac_acc: round-robin sparse multiply-accumulate engine.
//
// Scans N operand slots, takes at most one valid (a, b) pair per cycle under
// round-robin arbitration, multiplies it signed and accumulates the product
// into an ACC_SIZE-bit accumulator through a 3-stage pipeline
// (S1 operands -> S2 product -> S3 accumulate). A flush drains the pipeline
// for two fixed cycles and presents the result with a one-cycle done strobe.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   slot_valid[N]         slot i holds a pending pair
//   slot_a/slot_b         packed operands, slot i at [i*DATA_SIZE +: DATA_SIZE]
//   slot_ack[N]           one-hot (or zero) grant, combinational
//   start, flush          job control pulses
//   busy                  high in RUN or DRAIN
//   out_data, done        result and its one-cycle strobe
//   overflow              sticky signed-overflow flag of the current job
//
// Build option: define SPARSE_MAC_SAT_EN to saturate the accumulator on
// signed overflow instead of wrapping.

module sparse_mac_acc #(
  parameter int DATA_SIZE = 16,
  parameter int N         = 4,
  parameter int ACC_SIZE  = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           slot_valid,
  input  logic [N*DATA_SIZE-1:0] slot_a,
  input  logic [N*DATA_SIZE-1:0] slot_b,
  output logic [N-1:0]           slot_ack,
  input  logic                   start,
  input  logic                   flush,
  output logic                   busy,
  output logic [ACC_SIZE-1:0]    out_data,
  output logic                   done,
  output logic                   overflow
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic signed [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

  logic [1:0]    state_q, state_d;
  logic          drain_q, drain_d;
  logic [PW-1:0] ptr_q, ptr_d;

  // vld_pipe_q[0] = S1 valid, vld_pipe_q[1] = S2 valid
  logic [1:0]                    vld_pipe_q;
  logic signed [DATA_SIZE-1:0]   s1_a_q, s1_b_q;
  logic signed [2*DATA_SIZE-1:0] s2_prod_q;
  logic signed [ACC_SIZE-1:0]    acc_q;
  logic [ACC_SIZE-1:0]           out_q;
  logic                          ovf_q;

  // ---------------- arbitration ----------------
  logic          found, take;
  logic [PW-1:0] gidx, cand;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    // first valid slot starting at the pointer, wrapping around
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr_q) + k) % N);
      if (!found && slot_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    // the flush cycle never grants, so nothing enters after the drain starts
    take     = (state_q == S_RUN) && !flush && found;
    slot_ack = take ? (N'(1) << gidx) : '0;
    ptr_d    = ptr_q;
    if (take) ptr_d = (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
  end

  // ---------------- accumulate stage ----------------
  logic signed [2*DATA_SIZE-1:0] a_ext, b_ext;
  logic signed [ACC_SIZE-1:0]    prod_ext, sum, acc_nxt;
  logic                          add_ovf;

  always_comb begin
    a_ext    = s1_a_q;
    b_ext    = s1_b_q;
    prod_ext = s2_prod_q;  // sign-extends into the accumulator width
    sum      = acc_q + prod_ext;
    // same-sign operands producing a different-sign sum
    add_ovf  = (acc_q[ACC_SIZE-1] == prod_ext[ACC_SIZE-1]) &&
               (sum[ACC_SIZE-1] != acc_q[ACC_SIZE-1]);
`ifdef SPARSE_MAC_SAT_EN
    acc_nxt  = add_ovf ? (acc_q[ACC_SIZE-1] ? ACC_MIN : ACC_MAX) : sum;
`else
    acc_nxt  = sum;
`endif
  end

  // ---------------- control FSM ----------------
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (flush) begin state_d = S_DRAIN; drain_d = 1'b0; end
      // two cycles always empty S1/S2 and land the last product in acc
      S_DRAIN: if (drain_q) state_d = S_DONE; else drain_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  wire clear_job = (state_q == S_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      drain_q    <= 1'b0;
      ptr_q      <= '0;
      vld_pipe_q <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_prod_q  <= '0;
      acc_q      <= '0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      ptr_q      <= ptr_d;
      vld_pipe_q <= {vld_pipe_q[0], take};
      if (take) begin
        s1_a_q <= slot_a[gidx*DATA_SIZE +: DATA_SIZE];
        s1_b_q <= slot_b[gidx*DATA_SIZE +: DATA_SIZE];
      end
      if (vld_pipe_q[0]) s2_prod_q <= a_ext * b_ext;
      if (clear_job) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (vld_pipe_q[1]) begin
        acc_q <= acc_nxt;
        if (add_ovf) ovf_q <= 1'b1;
      end
      if (state_q == S_DRAIN && drain_q) out_q <= acc_q;
    end
  end

  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign out_data = out_q;
  assign overflow = ovf_q;

endmodule
